// File: rtl/seg7_pkg.sv
// Shared types and helpers for the multiplexed 4-digit 7-segment scan controller.
// One scan slot per digit, scanned leftmost (digit 3) first.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    typedef enum logic [1:0] {
        SCAN_D0 = 2'd0,
        SCAN_D1 = 2'd1,
        SCAN_D2 = 2'd2,
        SCAN_D3 = 2'd3
    } scan_state_e;

    // Anode enables are active-low: exactly one bit cleared selects a digit.
    localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;
    localparam logic [NUM_DIGITS-1:0] AN_D0  = 4'b1110;
    localparam logic [NUM_DIGITS-1:0] AN_D1  = 4'b1101;
    localparam logic [NUM_DIGITS-1:0] AN_D2  = 4'b1011;
    localparam logic [NUM_DIGITS-1:0] AN_D3  = 4'b0111;

    function automatic scan_state_e next_state(scan_state_e s);
        scan_state_e n;
        case (s)
            SCAN_D3: n = SCAN_D2;
            SCAN_D2: n = SCAN_D1;
            SCAN_D1: n = SCAN_D0;
            default: n = SCAN_D3;
        endcase
        return n;
    endfunction

    function automatic logic [1:0] digit_of(scan_state_e s);
        logic [1:0] d;
        case (s)
            SCAN_D3: d = 2'd3;
            SCAN_D2: d = 2'd2;
            SCAN_D1: d = 2'd1;
            default: d = 2'd0;
        endcase
        return d;
    endfunction

    function automatic logic [NUM_DIGITS-1:0] an_onecold(logic [1:0] d);
        logic [NUM_DIGITS-1:0] a;
        case (d)
            2'd3:    a = AN_D3;
            2'd2:    a = AN_D2;
            2'd1:    a = AN_D1;
            default: a = AN_D0;
        endcase
        return a;
    endfunction

    function automatic logic [3:0] nibble(logic [15:0] v, logic [1:0] d);
        return v[{d, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/seg7_scan_if.sv
// Host/display bundle of the scan controller; the controller takes the slave side.
// load is a one-cycle strobe that is always accepted (no ready); load_ack pulses
// later, together with frame_tick, when the staged digits reach the display.
interface seg7_scan_if;
    import seg7_pkg::*;

    logic [15:0] digits_in;
    logic        load;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic        lamp_test;

    logic [3:0]  bcd_out;
    logic        rbi_n;
    logic        lt_n;
    logic [3:0]  an;
    logic        dp;
    logic        load_ack;
    logic        frame_tick;
    scan_state_e dbg_state;

    modport master (
        output digits_in, load, dp_in, blank_lz, lamp_test,
        input  bcd_out, rbi_n, lt_n, an, dp, load_ack, frame_tick, dbg_state
    );

    modport slave (
        input  digits_in, load, dp_in, blank_lz, lamp_test,
        output bcd_out, rbi_n, lt_n, an, dp, load_ack, frame_tick, dbg_state
    );

endinterface

// File: rtl/seg7_refresh_div.sv
// Slot timer: counts 0..REFRESH_DIV-1, flags the wrap cycle and whether the
// following cycle falls inside the anode-off guard window.
module seg7_refresh_div #(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 16
) (
    input  logic clk,
    input  logic rst,
    output logic wrap_o,
    output logic guard_nxt_o
);

    localparam int CW = $clog2(REFRESH_DIV);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        wrap_o      = (cnt_q == CW'(REFRESH_DIV - 1));
        cnt_d       = wrap_o ? '0 : cnt_q + 1'b1;
        // Looks one cycle ahead so the registered anodes line up with the count.
        guard_nxt_o = (cnt_d < CW'(GUARD));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed BCD scan controller driving one shared 7-segment decoder,
// with double-buffered loads committed on frame boundaries and leading-zero blanking.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 16
) (
    input logic        clk,
    input logic        rst,
    seg7_scan_if.slave bus
);

    logic        wrap;
    logic        guard_nxt;
    logic        boundary;

    scan_state_e state_q, state_d;
    logic [15:0] stage_q, stage_d;
    logic [3:0]  stage_dp_q, stage_dp_d;
    logic [15:0] disp_q, disp_d;
    logic [3:0]  disp_dp_q, disp_dp_d;
    logic        pending_q, pending_d;
    logic        lz_q, lz_d;

    logic [3:0]  an_q;
    logic [3:0]  bcd_q;
    logic        rbi_n_q;
    logic        lt_n_q;
    logic        dp_q;
    logic        ack_q;
    logic        tick_q;

    logic [3:0]  cur_nib;
    logic [3:0]  nxt_nib;
    logic [1:0]  nxt_digit;
    logic        blank;

    seg7_refresh_div #(
        .REFRESH_DIV (REFRESH_DIV),
        .GUARD       (GUARD)
    ) u_div (
        .clk         (clk),
        .rst         (rst),
        .wrap_o      (wrap),
        .guard_nxt_o (guard_nxt)
    );

    assign boundary = wrap && (state_q == SCAN_D0);

    always_comb begin
        state_d    = wrap ? next_state(state_q) : state_q;
        stage_d    = stage_q;
        stage_dp_d = stage_dp_q;
        disp_d     = disp_q;
        disp_dp_d  = disp_dp_q;
        pending_d  = pending_q;

        // Commit the old staging first; a coincident load refills staging and stays pending.
        if (boundary && pending_q) begin
            disp_d    = stage_q;
            disp_dp_d = stage_dp_q;
            pending_d = 1'b0;
        end
        if (bus.load) begin
            stage_d    = bus.digits_in;
            stage_dp_d = bus.dp_in;
            pending_d  = 1'b1;
        end

        cur_nib = nibble(disp_q, digit_of(state_q));
        lz_d    = lz_q;
        if (wrap) begin
            if (state_d == SCAN_D3) begin
                lz_d = 1'b1;
            end else if (cur_nib != 4'd0) begin
                lz_d = 1'b0;
            end
        end

        // Outputs are computed from next-cycle values so they are valid from slot start.
        nxt_digit = digit_of(state_d);
        nxt_nib   = nibble(disp_d, nxt_digit);
        blank     = bus.blank_lz && lz_d && (nxt_nib == 4'd0) &&
                    (state_d != SCAN_D0) && !bus.lamp_test;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SCAN_D3;
            stage_q    <= '0;
            stage_dp_q <= '0;
            disp_q     <= '0;
            disp_dp_q  <= '0;
            pending_q  <= 1'b0;
            lz_q       <= 1'b1;
            an_q       <= AN_OFF;
            bcd_q      <= '0;
            rbi_n_q    <= 1'b1;
            lt_n_q     <= 1'b1;
            dp_q       <= 1'b1;
            ack_q      <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            stage_dp_q <= stage_dp_d;
            disp_q     <= disp_d;
            disp_dp_q  <= disp_dp_d;
            pending_q  <= pending_d;
            lz_q       <= lz_d;
            an_q       <= guard_nxt ? AN_OFF : an_onecold(nxt_digit);
            bcd_q      <= nxt_nib;
            rbi_n_q    <= ~blank;
            lt_n_q     <= ~bus.lamp_test;
            dp_q       <= bus.lamp_test ? 1'b0 : ~disp_dp_d[nxt_digit];
            ack_q      <= boundary && pending_q;
            tick_q     <= boundary;
        end
    end

    assign bus.an         = an_q;
    assign bus.bcd_out    = bcd_q;
    assign bus.rbi_n      = rbi_n_q;
    assign bus.lt_n       = lt_n_q;
    assign bus.dp         = dp_q;
    assign bus.load_ack   = ack_q;
    assign bus.frame_tick = tick_q;
    assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: a frame-time reference model (cycle index within a
// 4-slot frame, staged/displayed words) predicts every output each cycle.
module tb_seg7_scan_ctrl;
    import seg7_pkg::*;

    localparam int DIV   = 8;
    localparam int GRD   = 2;
    localparam int FRAME = 4 * DIV;
    localparam logic [12:0] RESET_VEC = {4'hF, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg7_scan_if bus ();

    seg7_scan_ctrl #(
        .REFRESH_DIV (DIV),
        .GUARD       (GRD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    // Reference model: m_t = cycles since reset release (0 while in reset).
    int          m_t;
    logic [15:0] m_stage, m_disp;
    logic [3:0]  m_stage_dp, m_disp_dp;
    bit          m_pend, m_ack, m_tick, m_lamp, m_blank;

    task automatic m_reset();
        m_t = 0; m_stage = '0; m_disp = '0; m_stage_dp = '0; m_disp_dp = '0;
        m_pend = 0; m_ack = 0; m_tick = 0; m_lamp = 0; m_blank = 0;
    endtask

    function automatic int cur_digit();
        return 3 - ((m_t / DIV) % 4);
    endfunction

    function automatic logic [12:0] exp_vec();
        int d, pos;
        logic [3:0] an_e, bcd_e;
        logic [15:0] lead;
        logic rbi_e, dp_e;
        if (m_t == 0) return RESET_VEC;
        d     = cur_digit();
        pos   = m_t % DIV;
        an_e  = 4'b0001 << d;
        an_e  = (pos >= GRD) ? ~an_e : 4'hF;
        bcd_e = m_disp[d*4 +: 4];
        lead  = m_disp >> (d * 4);
        rbi_e = !(m_blank && !m_lamp && d != 0 && lead == 16'h0);
        dp_e  = m_lamp ? 1'b0 : ~m_disp_dp[d];
        return {an_e, bcd_e, rbi_e, ~m_lamp, dp_e, m_ack, m_tick};
    endfunction

    function automatic logic [12:0] dut_vec();
        return {bus.an, bus.bcd_out, bus.rbi_n, bus.lt_n, bus.dp, bus.load_ack, bus.frame_tick};
    endfunction

    task automatic cycle();
        bit boundary;
        @(posedge clk);
        if (rst) begin
            m_reset();
        end else begin
            boundary = (m_t % FRAME) == FRAME - 1;
            m_tick   = boundary;
            m_ack    = boundary && m_pend;
            if (m_ack) begin
                m_disp = m_stage; m_disp_dp = m_stage_dp; m_pend = 0;
            end
            if (bus.load) begin
                m_stage = bus.digits_in; m_stage_dp = bus.dp_in; m_pend = 1;
            end
            m_lamp  = bus.lamp_test;
            m_blank = bus.blank_lz;
            m_t++;
        end
        #1;
    endtask

    task automatic load_word(input logic [15:0] d, input logic [3:0] dpv);
        bus.digits_in = d; bus.dp_in = dpv; bus.load = 1'b1;
        cycle();
        bus.load = 1'b0;
    endtask

    task automatic goto_phase(input int p);
        for (int i = 0; i < FRAME && (m_t % FRAME) != p; i++) cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.load = 1'b1; bus.digits_in = 16'($urandom); bus.dp_in = 4'($urandom);
            cycle();
            checks++;
            if (dut_vec() !== RESET_VEC || bus.dbg_state !== SCAN_D3) begin
                errors++;
                $display("FAIL reset_hold got=%h state=%0d exp=%h", dut_vec(), bus.dbg_state, RESET_VEC);
            end
        end
        bus.load = 1'b0;
        @(negedge clk) rst = 1'b0;
        cycle();
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_release got=%h exp=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_scan_order();
        logic [3:0] bcd_tab[4];
        logic [3:0] an_tab[4];
        int low_cnt;
        bcd_tab[0] = 4'd1; bcd_tab[1] = 4'd2; bcd_tab[2] = 4'd3; bcd_tab[3] = 4'd4;
        an_tab[0] = 4'b0111; an_tab[1] = 4'b1011; an_tab[2] = 4'b1101; an_tab[3] = 4'b1110;
        bus.blank_lz = 1'b0; bus.lamp_test = 1'b0;
        load_word(16'h1234, 4'($urandom));
        goto_phase(0);
        low_cnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            checks++;
            if (dut_vec() !== exp_vec() || bus.bcd_out !== bcd_tab[i / DIV] ||
                (bus.an !== 4'hF && bus.an !== an_tab[i / DIV])) begin
                errors++;
                $display("FAIL scan_order i=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
            end
            if (bus.an !== 4'hF) low_cnt++;
            if (i % DIV == DIV - 1) begin
                checks++;
                if (low_cnt != DIV - GRD) begin
                    errors++;
                    $display("FAIL scan_an_low slot=%0d got=%0d exp=%0d", i / DIV, low_cnt, DIV - GRD);
                end
                low_cnt = 0;
            end
            cycle();
        end
    endtask

    task automatic test_leading_zero();
        logic [15:0] words[2];
        logic rbi_tab[2][4];
        words[0] = 16'h0050; words[1] = 16'h0000;
        rbi_tab[0][0] = 0; rbi_tab[0][1] = 0; rbi_tab[0][2] = 1; rbi_tab[0][3] = 1;
        rbi_tab[1][0] = 0; rbi_tab[1][1] = 0; rbi_tab[1][2] = 0; rbi_tab[1][3] = 1;
        bus.blank_lz = 1'b1;
        for (int c = 0; c < 2; c++) begin
            goto_phase(4);
            load_word(words[c], 4'h0);
            goto_phase(0);
            for (int i = 0; i < FRAME; i++) begin
                checks++;
                if (dut_vec() !== exp_vec() || bus.rbi_n !== rbi_tab[c][i / DIV]) begin
                    errors++;
                    $display("FAIL leading_zero word=%h i=%0d got=%h exp=%h", words[c], i, dut_vec(), exp_vec());
                end
                cycle();
            end
        end
        bus.blank_lz = 1'b0;
    endtask

    task automatic test_load_buffer();
        int acks;
        logic [15:0] shown, want;
        goto_phase(2);
        load_word(16'h1111, 4'h0);
        goto_phase(12 + $urandom_range(0, 10));
        load_word(16'h2222, 4'h0);
        exp_q.push_back(16'h2222);
        acks = 0;
        for (int i = 0; i < FRAME && (m_t % FRAME) != 0; i++) begin
            cycle();
            if (bus.load_ack === 1'b1) acks++;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL load_buffer t=%0d got=%h exp=%h", m_t, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (acks != 1) begin
            errors++;
            $display("FAIL load_buffer_acks got=%0d exp=1", acks);
        end
        shown = '0;
        for (int i = 0; i < FRAME; i++) begin
            if (i % DIV == GRD) shown[cur_digit()*4 +: 4] = bus.bcd_out;
            cycle();
        end
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        checks++;
        if (shown !== want) begin
            errors++;
            $display("FAIL load_buffer_display got=%h exp=%h", shown, want);
        end
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 2; r++) begin
            goto_phase(4);
            if (r == 1) load_word(16'h5A5A, 4'h0);
            goto_phase(FRAME - 1);
            bus.digits_in = 16'h9999; bus.dp_in = 4'h0; bus.load = 1'b1;
            cycle();
            bus.load = 1'b0;
            checks++;
            if (dut_vec() !== exp_vec() || bus.load_ack !== (r == 1)) begin
                errors++;
                $display("FAIL collision_now r=%0d got=%h exp=%h", r, dut_vec(), exp_vec());
            end
            for (int i = 0; i < FRAME; i++) begin
                cycle();
                checks++;
                if (dut_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL collision_frame r=%0d t=%0d got=%h exp=%h", r, m_t, dut_vec(), exp_vec());
                end
            end
            checks++;
            if (bus.load_ack !== 1'b1 || bus.bcd_out !== 4'h9) begin
                errors++;
                $display("FAIL collision_next r=%0d ack=%b bcd=%h exp ack=1 bcd=9", r, bus.load_ack, bus.bcd_out);
            end
        end
    endtask

    task automatic test_lamp();
        bus.lamp_test = 1'b1; bus.blank_lz = 1'b1;
        goto_phase(3);
        load_word(16'h0000, 4'h0);
        goto_phase(0);
        for (int i = 0; i < FRAME; i++) begin
            checks++;
            if (dut_vec() !== exp_vec() || bus.lt_n !== 1'b0 || bus.rbi_n !== 1'b1 || bus.dp !== 1'b0) begin
                errors++;
                $display("FAIL lamp_test i=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
            end
            cycle();
        end
        bus.lamp_test = 1'b0; bus.blank_lz = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] w;
        for (int i = 0; i < 400; i++) begin
            bus.load = ($urandom_range(0, 7) == 0);
            for (int n = 0; n < 4; n++)
                w[n*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            bus.digits_in = w;
            bus.dp_in     = 4'($urandom);
            if ($urandom_range(0, 15) == 0) bus.blank_lz = ~bus.blank_lz;
            bus.lamp_test = ($urandom_range(0, 19) == 0);
            cycle();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random t=%0d got=%h exp=%h", m_t, dut_vec(), exp_vec());
            end
        end
        bus.load = 1'b0; bus.lamp_test = 1'b0; bus.blank_lz = 1'b0;
    endtask

    task automatic test_mid_reset();
        int acks;
        goto_phase(0);
        load_word(16'h4321, 4'hF);
        goto_phase(2 * DIV + 3);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (dut_vec() !== RESET_VEC || bus.dbg_state !== SCAN_D3) begin
            errors++;
            $display("FAIL mid_reset_async got=%h exp=%h", dut_vec(), RESET_VEC);
        end
        m_reset();
        cycle();
        checks++;
        if (dut_vec() !== RESET_VEC) begin
            errors++;
            $display("FAIL mid_reset_hold got=%h exp=%h", dut_vec(), RESET_VEC);
        end
        @(negedge clk) rst = 1'b0;
        cycle();
        checks++;
        if (bus.dbg_state !== SCAN_D3 || bus.bcd_out !== 4'h0 || dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL mid_reset_first state=%0d bcd=%h got=%h exp=%h", bus.dbg_state, bus.bcd_out, dut_vec(), exp_vec());
        end
        acks = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            cycle();
            if (bus.load_ack === 1'b1) acks++;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL mid_reset_run t=%0d got=%h exp=%h", m_t, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (acks != 0) begin
            errors++;
            $display("FAIL mid_reset_acks got=%0d exp=0", acks);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.digits_in = '0; bus.load = 1'b0; bus.dp_in = '0;
        bus.blank_lz = 1'b0; bus.lamp_test = 1'b0;
        m_reset();
        test_reset();
        test_scan_order();
        test_leading_zero();
        test_load_buffer();
        test_back_to_back();
        test_lamp();
        test_random();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
